change_hopper: RTL and testbench
================================

// Module: change_hopper
// PURPOSE
//  Change-return hopper controller. Consumes the one-hot, single-cycle coin-return pulses
//  (quarter/dime/nickel) that the vending controller emits and queues them in a FIFO.
//  Drives one motor per coin hopper, confirms every ejection on the shared coin sensor and
//  tracks hopper stock. Raises a fault on a jammed hopper; records shortfall for empty ones.
// PARAMETERS
//  QUEUE_DEPTH     8    request FIFO entries; power of 2, >=2
//  PULSE_CYCLES    4    motor-on cycles per ejection attempt; >=1
//  TIMEOUT_CYCLES  64   cycles to wait for coin_sense after motor pulse ends; >=1
//  INIT_STOCK      20   coins per hopper after reset or restock; 0..255
// PORTS
//  clk             in   1  system clock, rising edge
//  reset           in   1  asynchronous, active-low reset
//  inquarter       in   1  request one 25c coin (1-cycle pulse)
//  indime          in   1  request one 10c coin
//  innickel        in   1  request one 5c coin
//  coin_sense      in   1  ejection sensor, 1-cycle pulse per coin out
//  restock         in   1  pulse: all stock counters <= INIT_STOCK
//  clear_fault     in   1  pulse: leave FAULT, retry held coin
//  motorquarter    out  1  quarter hopper motor drive
//  motordime       out  1  dime hopper motor drive
//  motornickel     out  1  nickel hopper motor drive
//  busy            out  1  state!=IDLE or FIFO non-empty
//  fault           out  1  high while in FAULT
//  overflow        out  1  1-cycle pulse: request dropped (FIFO full)
//  req_error       out  1  1-cycle pulse: >1 request input high in one cycle
//  shortfall       out  8  cents owed from empty hoppers, saturates at 255
//  empty_mask      out  3  {quarter,dime,nickel} stock==0
// BEHAVIOUR
//  Reset (async assert, sync release): all outputs 0 except empty_mask=(INIT_STOCK==0)x3;
//   FIFO empty, state IDLE, stock=INIT_STOCK, shortfall=0. Reset mid-ejection aborts;
//   held coin and all queued requests are lost.
//  Enqueue: coin code quarter=0, dime=1, nickel=2. Multiple request inputs in one cycle:
//   only the highest-value coin is pushed (quarter>dime>nickel); req_error pulses next cycle.
//  FIFO full: push dropped, overflow pulses next cycle; a push and a pop in the same cycle
//   while full is accepted.
//  FSM, all outputs registered:
//   IDLE: FIFO non-empty and not fault -> pop head into cur_coin.
//     If stock[cur]==0: discard, shortfall+=value (saturating), stay IDLE.
//     Otherwise -> DRIVE.
//   DRIVE: motor[cur]=1 for exactly PULSE_CYCLES cycles, then -> WAIT (timer cleared).
//   WAIT: motors 0; timer counts up each cycle; timer==TIMEOUT_CYCLES -> FAULT.
//   coin_sense in DRIVE or WAIT: stock[cur]-=1, motor off next cycle, -> IDLE.
//   FAULT: fault=1, motors 0, FIFO keeps accepting pushes. clear_fault -> DRIVE, same cur_coin.
//   coin_sense in IDLE or FAULT is ignored.
//  Latency: request pulse in cycle N -> motor high from N+2 when IDLE and FIFO empty.
//  Back-to-back: after coin_sense, next pop occurs 1 cycle after IDLE entry; >=1 motor-off
//   cycle between any two ejections.
//  Stock: 8-bit per hopper, never decremented below 0. restock overrides a same-cycle
//   decrement. empty_mask is combinational from stock.
//  Counters use widths for TIMEOUT_CYCLES and PULSE_CYCLES, no wrap; shortfall never wraps.
// TESTING
//  T1 indime at cycle 0, coin_sense at cycle 4 -> motordime high cycles 2..4, stock_dime=19, busy low by 6.
//  T2 Queue inquarter, indime, innickel on consecutive cycles, sense after each pulse ->
//     motors fire in order Q, D, N; never two motors high at once.
//  T3 Push 9 requests while FAULT holds (QUEUE_DEPTH=8) -> 9th drops, overflow pulses once;
//     clear_fault drains the other 8.
//  T4 No coin_sense -> fault rises PULSE_CYCLES+TIMEOUT_CYCLES+1 after motor rise.
//     clear_fault -> motor re-pulses the same coin.
//  T5 INIT_STOCK=1, two innickel -> 1 ejection, then shortfall=5, empty_mask=3'b001;
//     restock clears the empty bit.
//  T6 inquarter and indime high together -> only quarter enqueued, req_error=1 one cycle.
//     Drop reset during DRIVE -> all outputs 0 immediately.

Source files
------------

// File: rtl/change_hopper.sv
// change_hopper: change-return hopper controller.
// Request FIFO feeding a motor/sense FSM with per-hopper stock tracking.
module change_hopper #(
    parameter int QUEUE_DEPTH    = 8,
    parameter int PULSE_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int INIT_STOCK     = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inquarter,
    input  logic       indime,
    input  logic       innickel,
    input  logic       coin_sense,
    input  logic       restock,
    input  logic       clear_fault,
    output logic       motorquarter,
    output logic       motordime,
    output logic       motornickel,
    output logic       busy,
    output logic       fault,
    output logic       overflow,
    output logic       req_error,
    output logic [7:0] shortfall,
    output logic [2:0] empty_mask
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int PW = $clog2(PULSE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [AW:0]   FULL_CNT    = (AW + 1)'(QUEUE_DEPTH);
    localparam logic [AW-1:0] PTR_ONE     = AW'(1);
    localparam logic [PW-1:0] PULSE_LAST  = PW'(PULSE_CYCLES - 1);
    localparam logic [PW-1:0] PCNT_ONE    = PW'(1);
    localparam logic [TW-1:0] TIMEOUT_END = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
    localparam logic [7:0]    STOCK_INIT  = 8'(INIT_STOCK);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    logic [1:0]    state, state_n;
    logic [1:0]    cur, cur_n;
    logic [PW-1:0] pcnt, pcnt_n;
    logic [TW-1:0] timer, timer_n;
    logic [1:0]    mem [QUEUE_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count, count_n;
    logic [7:0]    stock [3];
    logic [1:0]    head, req_code;
    logic [7:0]    head_stock, head_value;
    logic [8:0]    short_sum;
    logic [2:0]    motor_n;
    logic          req_any, req_multi, full, push, pop, dec, short_add;

    // Highest-value coin wins when several requests collide
    always_comb begin
        req_any   = inquarter | indime | innickel;
        req_multi = (inquarter & indime) | (inquarter & innickel) | (indime & innickel);
        req_code  = inquarter ? 2'd0 : (indime ? 2'd1 : 2'd2);
        full      = (count == FULL_CNT);
        pop       = (state == S_IDLE) && (count != '0);
        push      = req_any && (!full || pop);
        count_n   = count + (AW + 1)'(push) - (AW + 1)'(pop);
    end

    always_comb begin
        head = mem[rd_ptr];
        case (head)
            2'd0: begin
                head_stock = stock[0];
                head_value = 8'd25;
            end
            2'd1: begin
                head_stock = stock[1];
                head_value = 8'd10;
            end
            default: begin
                head_stock = stock[2];
                head_value = 8'd5;
            end
        endcase
        short_sum = {1'b0, shortfall} + {1'b0, head_value};
    end

    always_comb begin
        state_n   = state;
        cur_n     = cur;
        pcnt_n    = pcnt;
        timer_n   = timer;
        dec       = 1'b0;
        short_add = 1'b0;
        case (state)
            S_IDLE: begin
                if (pop) begin
                    cur_n = head;
                    if (head_stock == 8'd0) begin
                        short_add = 1'b1;
                    end else begin
                        state_n = S_DRIVE;
                        pcnt_n  = '0;
                    end
                end
            end
            S_DRIVE: begin
                if (coin_sense) begin
                    dec     = 1'b1;
                    state_n = S_IDLE;
                end else if (pcnt == PULSE_LAST) begin
                    state_n = S_WAIT;
                    timer_n = '0;
                end else begin
                    pcnt_n = pcnt + PCNT_ONE;
                end
            end
            S_WAIT: begin
                if (coin_sense) begin
                    dec     = 1'b1;
                    state_n = S_IDLE;
                end else if (timer == TIMEOUT_END) begin
                    state_n = S_FAULT;
                end else begin
                    timer_n = timer + TIMER_ONE;
                end
            end
            S_FAULT: begin
                if (clear_fault) begin
                    state_n = S_DRIVE;
                    pcnt_n  = '0;
                end
            end
        endcase
        motor_n = (state_n == S_DRIVE) ? (3'b100 >> cur_n) : 3'b000;
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= req_code;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            cur          <= 2'd0;
            pcnt         <= '0;
            timer        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            motorquarter <= 1'b0;
            motordime    <= 1'b0;
            motornickel  <= 1'b0;
            busy         <= 1'b0;
            fault        <= 1'b0;
            overflow     <= 1'b0;
            req_error    <= 1'b0;
            shortfall    <= 8'd0;
            for (int i = 0; i < 3; i++) stock[i] <= STOCK_INIT;
        end else begin
            state     <= state_n;
            cur       <= cur_n;
            pcnt      <= pcnt_n;
            timer     <= timer_n;
            count     <= count_n;
            overflow  <= req_any && !push;
            req_error <= req_multi;
            fault     <= (state_n == S_FAULT);
            busy      <= (state_n != S_IDLE) || (count_n != '0);
            {motorquarter, motordime, motornickel} <= motor_n;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) rd_ptr <= rd_ptr + PTR_ONE;
            if (short_add) shortfall <= short_sum[8] ? 8'hFF : short_sum[7:0];
            // Restock takes precedence over a same-cycle ejection
            if (restock) begin
                for (int i = 0; i < 3; i++) stock[i] <= STOCK_INIT;
            end else if (dec && stock[cur] != 8'd0) begin
                stock[cur] <= stock[cur] - 8'd1;
            end
        end
    end

    assign empty_mask = {stock[0] == 8'd0, stock[1] == 8'd0, stock[2] == 8'd0};

endmodule

// File: tb/tb_change_hopper.sv
// tb_change_hopper: directed and randomized bench for change_hopper.
// Reference model: request queue plus per-coin stock and shortfall totals.
module tb_change_hopper;
    localparam int QD = 8;
    localparam int P  = 4;
    localparam int T  = 64;
    localparam int IS = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       inquarter = 1'b0;
    logic       indime = 1'b0;
    logic       innickel = 1'b0;
    logic       coin_sense = 1'b0;
    logic       restock = 1'b0;
    logic       clear_fault = 1'b0;
    logic       motorquarter, motordime, motornickel;
    logic       busy, fault, overflow, req_error;
    logic [7:0] shortfall;
    logic [2:0] empty_mask;

    int checks = 0;
    int passed = 0;
    int fails = 0;
    int stock[3];
    int sf = 0;
    int mq[$];
    logic [2:0] stim[$];

    always #5 clk = ~clk;

    change_hopper #(
        .QUEUE_DEPTH(QD),
        .PULSE_CYCLES(P),
        .TIMEOUT_CYCLES(T),
        .INIT_STOCK(IS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .inquarter(inquarter),
        .indime(indime),
        .innickel(innickel),
        .coin_sense(coin_sense),
        .restock(restock),
        .clear_fault(clear_fault),
        .motorquarter(motorquarter),
        .motordime(motordime),
        .motornickel(motornickel),
        .busy(busy),
        .fault(fault),
        .overflow(overflow),
        .req_error(req_error),
        .shortfall(shortfall),
        .empty_mask(empty_mask)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int coin_val(input int c);
        return (c == 0) ? 25 : ((c == 1) ? 10 : 5);
    endfunction

    function automatic int top_code(input logic [2:0] v);
        return v[2] ? 0 : (v[1] ? 1 : 2);
    endfunction

    function automatic int motor_code();
        if (motorquarter) return 0;
        if (motordime) return 1;
        if (motornickel) return 2;
        return -1;
    endfunction

    function automatic logic [2:0] model_mask();
        return {stock[0] == 0, stock[1] == 0, stock[2] == 0};
    endfunction

    // Next coin to physically leave; empty-hopper requests become shortfall
    function automatic int model_next();
        int c;
        while (mq.size() > 0) begin
            c = mq.pop_front();
            if (stock[c] > 0) return c;
            sf += coin_val(c);
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) stock[i] = IS;
        sf = 0;
        mq.delete();
    endfunction

    task automatic serve(input int max_cycles);
        int cd;
        int cur;
        int prev;
        int last_req;
        int m;
        int c;
        bit done;
        logic multi_q;
        logic [2:0] v;
        cd = -1;
        cur = 0;
        prev = -1;
        last_req = 0;
        done = 0;
        multi_q = 1'b0;
        for (int cyc = 0; cyc < max_cycles && !done; cyc++) begin
            m = motor_code();
            chk("motor_onehot", 32'($onehot0({motorquarter, motordime, motornickel})), 1);
            chk("req_error", req_error, multi_q);
            chk("fault_low", fault, 0);
            chk("overflow_low", overflow, 0);
            chk("empty_mask", empty_mask, model_mask());
            if (m >= 0 && prev < 0) begin
                chk("eject_coin", m, model_next());
                cur = m;
                cd = $urandom_range(0, P + 8);
            end
            coin_sense = 1'b0;
            if (cd == 0) begin
                coin_sense = 1'b1;
                if (stock[cur] > 0) stock[cur]--;
            end
            if (cd >= 0) cd--;
            v = 3'b000;
            if (stim.size() > 0 && mq.size() < 6 && $urandom_range(0, 1) == 1) begin
                v = stim.pop_front();
                mq.push_back(top_code(v));
                last_req = cyc;
            end
            {inquarter, indime, innickel} = v;
            multi_q = ($countones(v) > 1);
            if (stim.size() == 0 && cd < 0 && m < 0 && !busy && cyc - last_req > 3)
                done = 1;
            prev = m;
            tick();
        end
        {inquarter, indime, innickel} = 3'b000;
        coin_sense = 1'b0;
        if (!done) chk("serve_timeout", 0, 1);
        while (mq.size() > 0) begin
            c = mq.pop_front();
            chk("leftover_empty", stock[c], 0);
            sf += coin_val(c);
        end
        chk("shortfall", shortfall, (sf > 255) ? 255 : sf);
        chk("mask_end", empty_mask, model_mask());
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] v;
        int r;
        int k;
        model_reset();
        tick();
        chk("rst_motors", {motorquarter, motordime, motornickel}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fault", fault, 0);
        chk("rst_shortfall", shortfall, 0);
        chk("rst_mask", empty_mask, 0);
        reset = 1'b1;
        tick();

        // T1: dime request, sensed in the last driven cycle
        indime = 1'b1;
        chk("t1_c0", motordime, 0);
        tick();
        indime = 1'b0;
        chk("t1_c1", motordime, 0);
        chk("t1_busy", busy, 1);
        tick();
        chk("t1_c2", motordime, 1);
        tick();
        chk("t1_c3", motordime, 1);
        tick();
        chk("t1_c4", motordime, 1);
        coin_sense = 1'b1;
        stock[1]--;
        tick();
        coin_sense = 1'b0;
        chk("t1_c5", motordime, 0);
        tick();
        chk("t1_idle", busy, 0);

        // T6a: colliding requests
        inquarter = 1'b1;
        indime = 1'b1;
        tick();
        inquarter = 1'b0;
        indime = 1'b0;
        chk("t6_req_error", req_error, 1);
        tick();
        chk("t6_req_error_off", req_error, 0);
        chk("t6_quarter", motorquarter, 1);
        chk("t6_no_dime", motordime, 0);
        coin_sense = 1'b1;
        stock[0]--;
        tick();
        coin_sense = 1'b0;
        tick();
        tick();
        chk("t6_no_dime_queued", busy, 0);

        // T4: missing sensor pulse leads to fault, then retry
        innickel = 1'b1;
        tick();
        innickel = 1'b0;
        tick();
        chk("t4_rise", motornickel, 1);
        repeat (P + T) tick();
        chk("t4_pre_fault", fault, 0);
        tick();
        chk("t4_fault", fault, 1);
        chk("t4_motors_off", {motorquarter, motordime, motornickel}, 0);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        chk("t4_retry", motornickel, 1);
        chk("t4_fault_clr", fault, 0);
        coin_sense = 1'b1;
        stock[2]--;
        tick();
        coin_sense = 1'b0;
        chk("t4_done", motornickel, 0);
        tick();
        tick();
        chk("t4_idle", busy, 0);

        // T2: ordered Q, D, N
        stim.push_back(3'b100);
        stim.push_back(3'b010);
        stim.push_back(3'b001);
        serve(500);

        // T3: fill the FIFO while a quarter is jammed
        inquarter = 1'b1;
        tick();
        inquarter = 1'b0;
        k = 0;
        while (k < P + T + 10 && !fault) begin
            tick();
            k++;
        end
        chk("t3_fault", fault, 1);
        mq.push_back(0);
        for (int i = 0; i <= 10; i++) begin
            chk("t3_overflow", overflow, (i == 9));
            chk("t3_busy", busy, 1);
            {inquarter, indime, innickel} = 3'b000;
            if (i < 9) begin
                v = ($urandom_range(0, 1) == 1) ? 3'b010 : 3'b001;
                {inquarter, indime, innickel} = v;
                if (i < 8) mq.push_back(top_code(v));
            end
            tick();
        end
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        serve(3000);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 7);
            if (r == 0) begin
                v = 3'b111;
                r = $urandom_range(0, 3);
                if (r == 0) v = 3'b110;
                if (r == 1) v = 3'b011;
                if (r == 2) v = 3'b101;
            end else begin
                v = 3'b100 >> $urandom_range(0, 2);
            end
            stim.push_back(v);
        end
        serve(6000);

        // Exhaust the dime hopper
        r = stock[1];
        for (int i = 0; i <= r; i++) stim.push_back(3'b010);
        serve(4000);
        chk("dime_empty", empty_mask[1], 1);

        restock = 1'b1;
        tick();
        restock = 1'b0;
        for (int i = 0; i < 3; i++) stock[i] = IS;
        chk("restock_mask", empty_mask, 0);

        // T5: nickel hopper runs dry
        for (int i = 0; i <= IS; i++) stim.push_back(3'b001);
        serve(4000);
        chk("t5_mask", empty_mask, 3'b001);
        restock = 1'b1;
        tick();
        restock = 1'b0;
        for (int i = 0; i < 3; i++) stock[i] = IS;
        chk("t5_restock", empty_mask, 0);

        // T6b: reset mid-ejection
        indime = 1'b1;
        tick();
        indime = 1'b0;
        tick();
        tick();
        chk("t6_driving", motordime, 1);
        reset = 1'b0;
        #1;
        chk("t6_rst_motor", motordime, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_short", shortfall, 0);
        chk("t6_rst_mask", empty_mask, 0);
        tick();
        reset = 1'b1;
        model_reset();
        tick();
        chk("t6_after_busy", busy, 0);
        stim.push_back(3'b100);
        serve(500);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
